// File: rtl/pp_accumulator.sv
// Partial-product accumulator: sums shifted tile products into a 512-bit
// result and hands the finished product downstream over valid/ready.
module pp_accumulator #(
  parameter int unsigned PP_W  = 42,
  parameter int unsigned SH_W  = 9,
  parameter int unsigned ACC_W = 512,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [PP_W-1:0]  pp_data,
  input  logic [SH_W-1:0]  pp_shift,
  input  logic             pp_last,
  output logic [ACC_W-1:0] P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pp_count,
  output logic             ovf
);

  localparam int unsigned EXT_W = ACC_W + PP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             ready_nxt;
  logic             valid_nxt;

  logic             beat_c;
  logic [EXT_W-1:0] term_ext_c;
  logic [ACC_W-1:0] term_c;
  logic             discard_c;
  logic [ACC_W:0]   sum_c;

  // Term path: widened shift so bits pushed past the accumulator can be detected.
  assign beat_c     = pp_valid & pp_ready;
  assign term_ext_c = EXT_W'(pp_data) << pp_shift;
  assign term_c     = term_ext_c[ACC_W-1:0];
  assign discard_c  = |term_ext_c[EXT_W-1:ACC_W];
  assign sum_c      = {1'b0, acc} + {1'b0, term_c};

  assign P = acc;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (beat_c) begin
          state_nxt = pp_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; the first beat of a product reloads rather than adds.
  always_comb begin
    acc_nxt   = acc;
    cnt_nxt   = pp_count;
    ovf_nxt   = ovf;
    ready_nxt = (state_nxt != DONE);
    valid_nxt = (state_nxt == DONE);
    case (state)
      IDLE: begin
        if (beat_c) begin
          acc_nxt = term_c;
          cnt_nxt = CNT_W'(1);
          ovf_nxt = discard_c;
        end
      end
      ACCUM: begin
        if (beat_c) begin
          acc_nxt = sum_c[ACC_W-1:0];
          cnt_nxt = (pp_count == CNT_MAX) ? pp_count : pp_count + CNT_W'(1);
          ovf_nxt = ovf | sum_c[ACC_W] | discard_c;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      pp_count  <= '0;
      ovf       <= 1'b0;
      pp_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      pp_count  <= cnt_nxt;
      ovf       <= ovf_nxt;
      pp_ready  <= ready_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// Scoreboard bench for pp_accumulator: products are reduced by plain wide
// arithmetic (or a direct multiply) and compared when out_valid is consumed.
module tb_pp_accumulator;

  typedef struct packed {
    logic [511:0] p;
    logic [7:0]   cnt;
    logic         ovf;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         pp_valid;
  logic         pp_ready;
  logic [41:0]  pp_data;
  logic [8:0]   pp_shift;
  logic         pp_last;
  logic [511:0] P;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pp_count;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_rdy = 0;

  exp_t        exp_q[$];
  logic [41:0] bd[$];
  logic [8:0]  bs[$];

  pp_accumulator dut (
    .clock     (clock),
    .reset     (reset),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_data   (pp_data),
    .pp_shift  (pp_shift),
    .pp_last   (pp_last),
    .P         (P),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_count  (pp_count),
    .ovf       (ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: exact sum of all terms; anything at or above 2^512 means overflow.
  function automatic exp_t model_beats();
    logic [1023:0] total;
    exp_t e;
    total = '0;
    foreach (bd[i]) total += 1024'(bd[i]) << bs[i];
    e.p   = total[511:0];
    e.ovf = |total[1023:512];
    e.cnt = (bd.size() > 255) ? 8'd255 : 8'(bd.size());
    return e;
  endfunction

  task automatic send_beat(input logic [41:0] d, input logic [8:0] s, input logic l);
    int waited;
    waited   = 0;
    pp_valid = 1'b1;
    pp_data  = d;
    pp_shift = s;
    pp_last  = l;
    while (!pp_ready && waited < 1000) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!pp_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_accept_timeout: pp_ready stuck at %0b, want 1", pp_ready);
    end else begin
      @(posedge clock); #1;
    end
    pp_valid = 1'b0;
    pp_data  = 'x;
    pp_shift = 'x;
    pp_last  = 1'b0;
  endtask

  // Streams bd/bs with last on the final beat, then records the expected result.
  task automatic send_product(input exp_t e, input bit gaps);
    for (int i = 0; i < bd.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
      send_beat(bd[i], bs[i], i == bd.size() - 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic product_from_beats(input bit gaps);
    exp_t e;
    e = model_beats();
    send_product(e, gaps);
  endtask

  // Tiles 256-bit X and Y into 21-bit limbs; each limb product fits a 42-bit beat.
  task automatic multiply(input logic [255:0] x, input logic [255:0] y);
    logic [272:0] xe;
    logic [272:0] ye;
    logic [511:0] prod;
    exp_t e;
    xe = 273'(x);
    ye = 273'(y);
    bd.delete();
    bs.delete();
    for (int i = 0; i < 13; i++)
      for (int j = 0; j < 13; j++) begin
        bd.push_back(42'(xe[21*i +: 21]) * 42'(ye[21*j +: 21]));
        bs.push_back(9'(21 * (i + j)));
      end
    prod  = 512'(x) * 512'(y);
    e.p   = prod;
    e.cnt = 8'd169;
    e.ovf = 1'b0;
    send_product(e, 1'b0);
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    rand_rdy  = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clock); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid & ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got P=%h, want no output", P);
        end else begin
          e = exp_q.pop_front();
          chk("result_P", P, e.p);
          chk("result_count", 512'(pp_count), 512'(e.cnt));
          chk("result_ovf", 512'(ovf), 512'(e.ovf));
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic [511:0] p0;
    logic [255:0] x;
    logic [255:0] y;

    reset     = 1'b0;
    pp_valid  = 1'b0;
    pp_data   = 'x;
    pp_shift  = 'x;
    pp_last   = 1'b0;
    out_ready = 1'b1;

    #2;
    chk("rst_pp_ready", 512'(pp_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_P", P, '0);
    chk("rst_count", 512'(pp_count), 512'(0));
    #20 reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_release", 512'(pp_ready), 512'(1));

    // Single beat
    bd = '{42'h3_FFFF_FFFF}; bs = '{9'd0};
    product_from_beats(0);
    // Carry ripple into bit 42
    bd = '{42'd1, 42'h3FF_FFFF_FFFF}; bs = '{9'd0, 9'd0};
    product_from_beats(0);
    // Discard past bit 511
    bd = '{42'h3}; bs = '{9'd511};
    product_from_beats(0);
    // Carry out of bit 511
    bd = '{42'd1, 42'd1}; bs = '{9'd511, 9'd511};
    product_from_beats(0);
    // Counter saturation
    bd.delete(); bs.delete();
    for (int i = 0; i < 300; i++) begin bd.push_back(42'd1); bs.push_back(9'd0); end
    product_from_beats(0);
    drain();

    // Full products
    multiply({256{1'b1}}, {256{1'b1}});
    drain();
    rand_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8; w++) begin
        x[32*w +: 32] = $urandom;
        y[32*w +: 32] = $urandom;
      end
      multiply(x, y);
    end

    // Random short products with random offsets (some overflow)
    for (int k = 0; k < 25; k++) begin
      bd.delete(); bs.delete();
      repeat ($urandom_range(1, 8)) begin
        bd.push_back({10'($urandom), 32'($urandom)});
        bs.push_back((k % 4 == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom));
      end
      product_from_beats(1);
    end
    drain();

    // Backpressure: held result stays stable while a new beat waits
    out_ready = 1'b0;
    bd = '{42'h123_4567_89AB}; bs = '{9'd100};
    product_from_beats(0);
    p0 = P;
    pp_valid = 1'b1; pp_data = 42'd7; pp_shift = 9'd0; pp_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      chk("bp_pp_ready", 512'(pp_ready), 512'(0));
      chk("bp_out_valid", 512'(out_valid), 512'(1));
      chk("bp_P_stable", P, p0);
    end
    out_ready = 1'b1;
    bd = '{42'd7}; bs = '{9'd0};
    product_from_beats(0);
    drain();

    // Asynchronous reset mid-accumulation
    send_beat(42'd11, 9'd3, 1'b0);
    send_beat(42'd12, 9'd40, 1'b0);
    send_beat(42'd13, 9'd80, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("abort_out_valid", 512'(out_valid), 512'(0));
    chk("abort_P", P, '0);
    chk("abort_count", 512'(pp_count), 512'(0));
    chk("abort_pp_ready", 512'(pp_ready), 512'(0));
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_ready_release", 512'(pp_ready), 512'(1));
    bd = '{42'd5}; bs = '{9'd0};
    product_from_beats(0);
    drain();

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
